cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 4, number of functional-unit requesters (ALU, MUL/DIV, BR, LD) sharing one common data bus.
REQ-002 Parameter PREG_W, default 6, physical register index width.
REQ-003 Parameter ROB_IDX_W, default 5, ROB entry index width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 fu_valid  input  NUM_FU  per-FU result valid.
REQ-007 fu_pd  input  NUM_FU x PREG_W  per-FU destination physical register.
REQ-008 fu_rd  input  NUM_FU x 5  per-FU architectural destination.
REQ-009 fu_rob_idx  input  NUM_FU x ROB_IDX_W  per-FU ROB entry.
REQ-010 fu_data  input  NUM_FU x 32  per-FU result value.
REQ-011 fu_ready  output  NUM_FU  per-FU accept; one-hot or zero.
REQ-012 cdb_ready  input  1  downstream (ROB/RS/PRF) can take a broadcast this cycle.
REQ-013 flush  input  1  branch-mispredict flush; kills all in-flight results.
REQ-014 cdb_valid  output  1  broadcast valid.
REQ-015 cdb_pd, cdb_rd, cdb_rob_idx, cdb_data  output  PREG_W/5/ROB_IDX_W/32  broadcast payload.

Function
REQ-016 Transfer from FU i SHALL occur in a cycle where fu_valid[i] and fu_ready[i] are both 1.
REQ-017 fu_ready[i] SHALL be combinational: 1 only for the single winning FU, and only when the output register is empty or is draining (cdb_ready=1), and flush=0.
REQ-018 Winner SHALL be the first requesting FU at or after rr_ptr, scanning upward modulo NUM_FU.
REQ-019 rr_ptr (log2(NUM_FU) bits) SHALL advance to (winner+1) mod NUM_FU on every transfer and SHALL hold otherwise.
REQ-020 Accepted payload SHALL appear on cdb_* with cdb_valid=1 exactly one cycle after transfer (registered output, latency 1).
REQ-021 Output register SHALL hold value and cdb_valid while cdb_valid=1 and cdb_ready=0; no grant in that cycle.
REQ-022 cdb_valid=1 with cdb_ready=1 and a new transfer same cycle SHALL load the new payload (back-to-back, one broadcast per cycle).
REQ-023 cdb_valid=1 with cdb_ready=1 and no transfer SHALL clear cdb_valid next cycle.
REQ-024 flush=1 SHALL clear cdb_valid next cycle, suppress all fu_ready that cycle, and leave rr_ptr unchanged.
REQ-025 With fu_valid all zero, fu_ready SHALL be zero and rr_ptr SHALL hold.
REQ-026 Fairness: a continuously requesting FU SHALL be granted within NUM_FU consecutive transfers.
REQ-027 fu_ready SHALL never depend on fu_data/fu_pd/fu_rd/fu_rob_idx.
REQ-028 cdb_* payload when cdb_valid=0 is don't-care; benches SHALL not check it.

Reset
REQ-029 rst_n=0 SHALL asynchronously set cdb_valid=0, rr_ptr=0, payload registers=0.
REQ-030 While rst_n=0, fu_ready SHALL be all zero.
REQ-031 Reset asserted mid-broadcast SHALL drop cdb_valid immediately; first grant after release goes to lowest requesting index.

Verification
REQ-032 Reset release, fu_valid=4'b1010, cdb_ready=1 -> cycle0 fu_ready=4'b0010, cycle1 cdb_valid=1 with FU1 payload, rr_ptr=2; next grant FU3.
REQ-033 All four FUs valid continuously, cdb_ready=1 -> grants FU0,FU1,FU2,FU3,FU0 on consecutive cycles; cdb_valid stays 1.
REQ-034 FU2 accepted (pd=6'd17, data=32'hDEADBEEF), cdb_ready=0 for 3 cycles -> cdb_* held constant, fu_ready=0 throughout; on cdb_ready=1 next grant proceeds.
REQ-035 cdb_valid=1, flush=1 with fu_valid=4'b1111 -> fu_ready=0 that cycle, cdb_valid=0 next cycle, rr_ptr unchanged.
REQ-036 rst_n pulled low while cdb_valid=1 (mid-cycle) -> cdb_valid=0 before next clock edge; after release fu_valid=4'b1000 -> FU3 granted first.
REQ-037 Random fu_valid/cdb_ready/flush for 10k cycles -> fu_ready at most one-hot, no lost or duplicated transfer (scoreboard), starvation bound per REQ-026 holds.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_if
// Bundles the functional-unit result handshake and the common data bus
// broadcast for cdb_arbiter.
//   fu_valid/fu_pd/fu_rd/fu_rob_idx/fu_data : per-FU result offered to the bus
//   fu_ready   : per-FU accept (one-hot or zero)
//   cdb_ready  : downstream can take a broadcast this cycle
//   flush      : mispredict flush, kills in-flight results
//   cdb_*      : registered broadcast
// modport slave  : arbiter side
// modport master : FU / downstream side (testbench)
// ---------------------------------------------------------------------------
interface cdb_arbiter_if #(
    parameter int NUM_FU    = 4,
    parameter int PREG_W    = 6,
    parameter int ROB_IDX_W = 5
);
    logic [NUM_FU-1:0]                fu_valid;
    logic [NUM_FU-1:0][PREG_W-1:0]    fu_pd;
    logic [NUM_FU-1:0][4:0]           fu_rd;
    logic [NUM_FU-1:0][ROB_IDX_W-1:0] fu_rob_idx;
    logic [NUM_FU-1:0][31:0]          fu_data;
    logic [NUM_FU-1:0]                fu_ready;
    logic                             cdb_ready;
    logic                             flush;
    logic                             cdb_valid;
    logic [PREG_W-1:0]                cdb_pd;
    logic [4:0]                       cdb_rd;
    logic [ROB_IDX_W-1:0]             cdb_rob_idx;
    logic [31:0]                      cdb_data;

    modport slave (
        input  fu_valid, fu_pd, fu_rd, fu_rob_idx, fu_data, cdb_ready, flush,
        output fu_ready, cdb_valid, cdb_pd, cdb_rd, cdb_rob_idx, cdb_data
    );

    modport master (
        output fu_valid, fu_pd, fu_rd, fu_rob_idx, fu_data, cdb_ready, flush,
        input  fu_ready, cdb_valid, cdb_pd, cdb_rd, cdb_rob_idx, cdb_data
    );
endinterface

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
// Round-robin arbiter granting one functional unit per cycle onto a single
// registered common data bus (latency 1, back-to-back capable).
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : cdb_arbiter_if.slave (FU handshake in, CDB broadcast out)
// ---------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int NUM_FU    = 4,
    parameter int PREG_W    = 6,
    parameter int ROB_IDX_W = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    cdb_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [PTR_W-1:0]     r_rr_ptr;
    logic                 r_cdb_valid;
    logic [PREG_W-1:0]    r_cdb_pd;
    logic [4:0]           r_cdb_rd;
    logic [ROB_IDX_W-1:0] r_cdb_rob_idx;
    logic [31:0]          r_cdb_data;

    logic                 w_can_accept;
    logic                 w_found;
    logic [PTR_W-1:0]     w_winner;
    logic                 w_grant;

    // Index addition modulo NUM_FU; works for non-power-of-two NUM_FU.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= NUM_FU) s = s - NUM_FU;
        return PTR_W'(s);
    endfunction

    // Reset gating keeps every grant low while rst_n is held.
    assign w_can_accept = (!r_cdb_valid || bus.cdb_ready) && !bus.flush && rst_n;

    // Scan upward from the round-robin pointer; only fu_valid is looked at,
    // so grant timing is independent of payload contents.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (!w_found && bus.fu_valid[wrap_add(r_rr_ptr, k)]) begin
                w_found  = 1'b1;
                w_winner = wrap_add(r_rr_ptr, k);
            end
        end
    end

    assign w_grant      = w_found && w_can_accept;
    assign bus.fu_ready = w_grant ? (NUM_FU'(1) << w_winner) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr      <= '0;
            r_cdb_valid   <= 1'b0;
            r_cdb_pd      <= '0;
            r_cdb_rd      <= '0;
            r_cdb_rob_idx <= '0;
            r_cdb_data    <= '0;
        end else if (bus.flush) begin
            r_cdb_valid <= 1'b0;
        end else if (w_grant) begin
            r_cdb_valid   <= 1'b1;
            r_cdb_pd      <= bus.fu_pd[w_winner];
            r_cdb_rd      <= bus.fu_rd[w_winner];
            r_cdb_rob_idx <= bus.fu_rob_idx[w_winner];
            r_cdb_data    <= bus.fu_data[w_winner];
            r_rr_ptr      <= wrap_add(w_winner, 1);
        end else if (bus.cdb_ready) begin
            r_cdb_valid <= 1'b0;
        end
    end

    assign bus.cdb_valid   = r_cdb_valid;
    assign bus.cdb_pd      = r_cdb_pd;
    assign bus.cdb_rd      = r_cdb_rd;
    assign bus.cdb_rob_idx = r_cdb_rob_idx;
    assign bus.cdb_data    = r_cdb_data;
endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
// Self-checking bench for cdb_arbiter: directed vector table, hand-written
// hold/flush/reset sequences, and a randomized run against a queue-based
// reference model with a starvation monitor.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;
    localparam int N = 4;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    cdb_arbiter_if #(.NUM_FU(N), .PREG_W(6), .ROB_IDX_W(5)) bus ();

    cdb_arbiter #(.NUM_FU(N), .PREG_W(6), .ROB_IDX_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] fv;
        logic       cr;
        logic       fl;
        logic [3:0] exp_rdy;
        logic       exp_v;
        logic [1:0] exp_ptr;
    } vec_t;

    typedef struct {
        logic [5:0]  pd;
        logic [4:0]  rd;
        logic [4:0]  rob;
        logic [31:0] data;
    } pay_t;

    vec_t tbl [16];
    pay_t sb_q [$];
    int   wait_cnt [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic pay_t pay_of(input int tag, input int i);
        pay_t p;
        p.pd   = 6'(tag * 3 + i);
        p.rd   = 5'(tag + i);
        p.rob  = 5'(tag * 7 + i);
        p.data = (32'(tag) << 8) | 32'(i);
        return p;
    endfunction

    task automatic set_payload(input int tag);
        pay_t p;
        for (int i = 0; i < N; i++) begin
            p = pay_of(tag, i);
            bus.fu_pd[i]      = p.pd;
            bus.fu_rd[i]      = p.rd;
            bus.fu_rob_idx[i] = p.rob;
            bus.fu_data[i]    = p.data;
        end
    endtask

    task automatic apply(input logic [3:0] fv, input logic cr, input logic fl);
        bus.fu_valid  = fv;
        bus.cdb_ready = cr;
        bus.flush     = fl;
    endtask

    // Reference arbitration: first requester at or after ptr, modulo N.
    function automatic int pick(input logic [3:0] fv, input int ptr);
        for (int k = 0; k < N; k++)
            if (fv[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int w);
        logic [3:0] r;
        r = '0;
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    // Leaves the bench at posedge+1 with reset released.
    task automatic do_reset();
        apply(4'b0000, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   last_fu;
        int   mptr;
        int   w;
        pay_t p;
        pay_t exp_p;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        apply(4'b1111, 1'b1, 1'b0);
        set_payload(0);

        // Reset state, with requests present.
        #7;
        chk("rst_fu_ready", 64'(bus.fu_ready), 64'h0);
        chk("rst_cdb_valid", 64'(bus.cdb_valid), 64'h0);
        chk("rst_cdb_pd", 64'(bus.cdb_pd), 64'h0);
        chk("rst_cdb_data", 64'(bus.cdb_data), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'b0000, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // ---------------- table-driven directed vectors ----------------
        tbl[0]  = '{4'b1010, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd2};
        tbl[1]  = '{4'b1010, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd0};
        tbl[2]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd1};
        tbl[3]  = '{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd2};
        tbl[4]  = '{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd3};
        tbl[5]  = '{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd0};
        tbl[6]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd1};
        tbl[7]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1};
        tbl[8]  = '{4'b1111, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd1};
        tbl[9]  = '{4'b1111, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd2};
        tbl[10] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2};
        tbl[11] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2};
        tbl[12] = '{4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd1};
        tbl[13] = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd1};
        tbl[14] = '{4'b0110, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd1};
        tbl[15] = '{4'b0110, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd2};

        for (int i = 0; i < N; i++) begin
            bus.fu_pd[i]      = 6'(10 + i);
            bus.fu_rd[i]      = 5'(i + 1);
            bus.fu_rob_idx[i] = 5'(20 + i);
            bus.fu_data[i]    = 32'hA000_0000 + 32'(i);
        end
        last_fu = -1;
        for (int s = 0; s < 16; s++) begin
            apply(tbl[s].fv, tbl[s].cr, tbl[s].fl);
            #4;
            chk($sformatf("tbl%0d_fu_ready", s), 64'(bus.fu_ready), 64'(tbl[s].exp_rdy));
            for (int i = 0; i < N; i++)
                if (tbl[s].exp_rdy[i]) last_fu = i;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_cdb_valid", s), 64'(bus.cdb_valid), 64'(tbl[s].exp_v));
            chk($sformatf("tbl%0d_rr_ptr", s), 64'(dut.r_rr_ptr), 64'(tbl[s].exp_ptr));
            if (tbl[s].exp_v) begin
                chk($sformatf("tbl%0d_cdb_pd", s), 64'(bus.cdb_pd), 64'(10 + last_fu));
                chk($sformatf("tbl%0d_cdb_data", s), 64'(bus.cdb_data), 64'h0A000_0000 + 64'(last_fu));
            end
        end

        // ---------------- hold under back-pressure ----------------
        // State: cdb_valid=1 (FU1), rr_ptr=2.
        bus.fu_pd[2]   = 6'd17;
        bus.fu_data[2] = 32'hDEADBEEF;
        apply(4'b0100, 1'b1, 1'b0);
        #4;
        chk("hold_grant_fu2", 64'(bus.fu_ready), 64'b0100);
        @(posedge clk);
        #1;
        chk("hold_load_pd", 64'(bus.cdb_pd), 64'd17);
        for (int c = 0; c < 3; c++) begin
            apply(4'b1111, 1'b0, 1'b0);
            #4;
            chk($sformatf("hold%0d_fu_ready", c), 64'(bus.fu_ready), 64'h0);
            chk($sformatf("hold%0d_valid", c), 64'(bus.cdb_valid), 64'h1);
            chk($sformatf("hold%0d_pd", c), 64'(bus.cdb_pd), 64'd17);
            chk($sformatf("hold%0d_data", c), 64'(bus.cdb_data), 64'hDEADBEEF);
            @(posedge clk);
            #1;
        end
        apply(4'b1111, 1'b1, 1'b0);
        #4;
        chk("hold_release_grant", 64'(bus.fu_ready), 64'b1000);
        @(posedge clk);
        #1;
        chk("hold_release_pd", 64'(bus.cdb_pd), 64'd13);

        // ---------------- flush with broadcast pending ----------------
        // State: cdb_valid=1 (FU3), rr_ptr=0.
        apply(4'b1111, 1'b1, 1'b1);
        #4;
        chk("flush_fu_ready", 64'(bus.fu_ready), 64'h0);
        @(posedge clk);
        #1;
        chk("flush_valid_next", 64'(bus.cdb_valid), 64'h0);
        apply(4'b1111, 1'b1, 1'b0);
        #4;
        chk("flush_ptr_kept", 64'(bus.fu_ready), 64'b0001);
        @(posedge clk);
        #1;
        chk("flush_after_valid", 64'(bus.cdb_valid), 64'h1);

        // ---------------- async reset mid-broadcast ----------------
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(bus.cdb_valid), 64'h0);
        chk("midrst_fu_ready", 64'(bus.fu_ready), 64'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        apply(4'b1000, 1'b1, 1'b0);
        #1;
        chk("postrst_grant_fu3", 64'(bus.fu_ready), 64'b1000);
        @(posedge clk);
        #1;
        chk("postrst_valid", 64'(bus.cdb_valid), 64'h1);
        chk("postrst_pd", 64'(bus.cdb_pd), 64'd13);

        do_reset();
        apply(4'b0110, 1'b1, 1'b0);
        #4;
        chk("postrst_lowest", 64'(bus.fu_ready), 64'b0010);
        @(posedge clk);
        #1;

        // ---------------- randomized run vs reference model ----------------
        do_reset();
        sb_q.delete();
        mptr = 0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic [3:0] fv;
            logic       cr;
            logic       fl;
            fv = 4'($urandom);
            cr = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 31) == 0);
            apply(fv, cr, fl);
            set_payload(cyc + 1);
            #4;
            chk("rnd_cdb_valid", 64'(bus.cdb_valid), 64'(sb_q.size() > 0));
            if (sb_q.size() > 0 && bus.cdb_valid) begin
                exp_p = sb_q[0];
                chk("rnd_cdb_pd", 64'(bus.cdb_pd), 64'(exp_p.pd));
                chk("rnd_cdb_rd", 64'(bus.cdb_rd), 64'(exp_p.rd));
                chk("rnd_cdb_rob", 64'(bus.cdb_rob_idx), 64'(exp_p.rob));
                chk("rnd_cdb_data", 64'(bus.cdb_data), 64'(exp_p.data));
            end
            if (fl || (sb_q.size() > 0 && !cr)) w = -1;
            else                                w = pick(fv, mptr);
            chk("rnd_fu_ready", 64'(bus.fu_ready), 64'(onehot(w)));
            if (sb_q.size() > 0 && (fl || cr)) void'(sb_q.pop_front());
            if (w >= 0) begin
                p = pay_of(cyc + 1, w);
                sb_q.push_back(p);
                mptr = (w + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (!fv[i] || w == i) wait_cnt[i] = 0;
                else if (w >= 0) begin
                    wait_cnt[i]++;
                    if (wait_cnt[i] >= N) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL starvation fu%0d: waited %0d transfers, limit %0d", i, wait_cnt[i], N - 1);
                        wait_cnt[i] = 0;
                    end
                end
            end
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
